integrator_comb_decimator: RTL and testbench
============================================

# integrator_comb_decimator

Comb-and-decimate stage that sits directly downstream of the integrator top entity and consumes its signed output every clock. It keeps one of every `DECIM` integrator samples and outputs the `DELAY`-sample difference of the kept samples. Together with the integrator this forms a single-stage CIC decimator. Results are presented on a valid/ready output port with hold-on-stall and drop-on-overrun behaviour.

## Interface
- `WIDTH`, default 10: sample width. This matches the integrator output, signed two's complement.
- `DECIM`, default 4: decimation ratio. Legal range ≥ 2.
- `DELAY`, default 1: differential delay in decimated samples. Legal values 1 or 2.

Ports:
- `system1000`, in, 1: clock, shared with the integrator.
- `system1000_rstn`, in, 1: reset, asynchronous, active-low.
- `en_i`, in, 1: input sample strobe. Tied high when fed by the integrator.
- `integ_i`, in, `WIDTH`, signed: integrator output (`topLet_o`).
- `comb_o`, out, `WIDTH`, signed: comb difference.
- `comb_valid_o`, out, 1: `comb_o` holds an untransferred result.
- `comb_ready_i`, in, 1: downstream accepts `comb_o`.
- `overrun_o`, out, 1: sticky drop flag. Present only with `COMB_OVERRUN_EN`.

## Operation
- **Phase counter** runs 0..`DECIM`-1.
  - Advances only when `en_i` = 1.
  - Wraps from `DECIM`-1 to 0.
  - Holds when `en_i` = 0.
- **Decimation event (DE):** `en_i` = 1 and counter = `DECIM`-1. On a DE, `integ_i` is the kept sample d[k].
- **Delay line:** `DELAY` registers of kept samples, reset to 0, shifted on every DE.
- **Difference:** diff = d[k] − d[k−`DELAY`].
  - Computed modulo 2^`WIDTH`, wrap-around and never saturated. This is required for CIC correctness across integrator wrap.
- **Output FSM** has two states:
  - **EMPTY** (`comb_valid_o` = 0):
    - DE → load diff into `comb_o`, go to FULL.
  - **FULL** (`comb_valid_o` = 1):
    - `comb_ready_i` = 1 and no DE → transfer, go to EMPTY.
    - `comb_ready_i` = 1 and DE → transfer and load new diff in the same edge, stay FULL, no drop.
    - `comb_ready_i` = 0 and DE → `comb_o` unchanged, new diff dropped, overrun event.
    - `comb_ready_i` = 0 and no DE → hold.
- **Delay line on a dropped sample:** it still shifts, so later differences stay mathematically correct.
- **Output stability:** `comb_o` never changes while `comb_valid_o` = 1 and `comb_ready_i` = 0.

## Timing
- **Latency:** diff appears on `comb_o`, with `comb_valid_o` = 1, after the clock edge on which the DE is sampled. That is one cycle from `integ_i`.
- **Transfer:** completes on the rising edge where `comb_valid_o` and `comb_ready_i` are both 1.
- **Throughput:** at most one result per `DECIM` enabled cycles. Overrun is possible only if `comb_ready_i` stays low for ≥ `DECIM` enabled cycles while FULL.
- **Reset values**, applied immediately on `system1000_rstn` low with no clock edge needed:
  - counter = 0, delay line = 0.
  - `comb_o` = 0, `comb_valid_o` = 0, `overrun_o` = 0.
- **Reset mid-operation:** any pending result is discarded. After release, the first DE occurs on the `DECIM`-th enabled cycle, and its output is d[0] − 0.
- `comb_ready_i` is ignored in EMPTY.

## Configuration
- **`COMB_OVERRUN_EN` defined:**
  - `overrun_o` port exists.
  - It is set on the edge following the first overrun event.
  - It stays high until reset.
- **Not defined:**
  - Port absent, register absent.
  - Drop behaviour is identical.

## Test plan
All scenarios use `WIDTH`=10, `DECIM`=4, `DELAY`=1, `en_i`=1 and `comb_ready_i`=1 unless stated otherwise.

1. **Ramp:** `integ_i` = 0,1,2,… from reset release → DEs on samples 3, 7, 11 → `comb_o` = 3, 4, 4 … with one valid pulse per 4 cycles.
2. **Constant:** `integ_i` = 100 → `comb_o` = 100, then 0 thereafter.
3. **Wrap:** kept samples 500 then −508, i.e. 516 wrapped → `comb_o` = 16. There must be no saturation.
4. **Backpressure:** `comb_ready_i` = 0 across two DEs → first result held stable, second dropped, `overrun_o` = 1. Then ready high for 1 cycle → single transfer, `comb_valid_o` = 0. The next result must be correct, e.g. 4 on the ramp.
5. **Simultaneous:** `comb_ready_i` = 1 exactly on a DE while FULL → old value transferred, new value loaded, `comb_valid_o` stays 1, `overrun_o` stays 0.
6. **Reset:** async reset asserted between clock edges mid-frame → all outputs 0 before the next edge. After release the ramp restarts and the first output equals the kept sample value. Also: `en_i` = 0 for 5 cycles → counter frozen, DE delayed by exactly 5 cycles.

Source files
------------

// File: rtl/integrator_comb_decimator.sv
// Comb-and-decimate stage completing a single-stage CIC after the integrator.
// Optional sticky drop flag on overrun_o when COMB_OVERRUN_EN is defined.
module integrator_comb_decimator #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DECIM = 4,
  parameter int unsigned DELAY = 1
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] integ_i,
  output logic signed [WIDTH-1:0] comb_o,
  output logic                    comb_valid_o,
  input  logic                    comb_ready_i
`ifdef COMB_OVERRUN_EN
  ,
  output logic                    overrun_o
`endif
);

  localparam int unsigned    CW         = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0]  PHASE_LAST = CW'(DECIM - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           phase_q, phase_d;
  logic signed [WIDTH-1:0] dly_q [DELAY];
  logic signed [WIDTH-1:0] comb_q;
  logic signed [WIDTH-1:0] diff_d;
  logic                    de;

  always_comb begin
    de = en_i && (phase_q == PHASE_LAST);
  end

  always_comb begin
    phase_d = phase_q;
    if (de) begin
      phase_d = '0;
    end else if (en_i) begin
      phase_d = phase_q + 1'b1;
    end
  end

  // Plain modular subtraction: wrap is what keeps the CIC exact across
  // integrator overflow, so no saturation here.
  always_comb begin
    diff_d = integ_i - dly_q[DELAY-1];
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Shifts on every decimation event, including dropped ones.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      for (int unsigned i = 0; i < DELAY; i++) begin
        dly_q[i] <= '0;
      end
    end else if (de) begin
      dly_q[0] <= integ_i;
      for (int unsigned i = 1; i < DELAY; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

`ifdef COMB_OVERRUN_EN
  logic overrun_q;
`endif

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q   <= EMPTY;
      comb_q    <= '0;
`ifdef COMB_OVERRUN_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (de) begin
            comb_q  <= diff_d;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (comb_ready_i) begin
            if (de) begin
              comb_q <= diff_d;
            end else begin
              state_q <= EMPTY;
            end
          end else if (de) begin
`ifdef COMB_OVERRUN_EN
            overrun_q <= 1'b1;
`endif
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign comb_o       = comb_q;
  assign comb_valid_o = (state_q == FULL);
`ifdef COMB_OVERRUN_EN
  assign overrun_o    = overrun_q;
`endif

endmodule

// File: tb/tb_integrator_comb_decimator.sv
// Directed self-checking bench for integrator_comb_decimator (WIDTH=10, DECIM=4, DELAY=1).
module tb_integrator_comb_decimator;

  localparam int unsigned W = 10;

  logic                clk;
  logic                rstn;
  logic                en;
  logic signed [W-1:0] integ;
  logic signed [W-1:0] comb;
  logic                valid;
  logic                ready;
`ifdef COMB_OVERRUN_EN
  logic                overrun;
`endif

  int passed = 0;
  int total  = 0;

  integrator_comb_decimator #(
    .WIDTH(W),
    .DECIM(4),
    .DELAY(1)
  ) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .en_i            (en),
    .integ_i         (integ),
    .comb_o          (comb),
    .comb_valid_o    (valid),
    .comb_ready_i    (ready)
`ifdef COMB_OVERRUN_EN
    ,
    .overrun_o       (overrun)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input int x, input logic e, input logic r);
    integ = W'(x);
    en    = e;
    ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rstn  = 1'b0;
    integ = '0;
    en    = 1'b1;
    ready = 1'b1;
    @(posedge clk);
    #3;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (comb !== '0) $display("FAIL reset_comb: got %0d expected 0", comb); else passed++;
    total++;
    if (valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", valid); else passed++;
`ifdef COMB_OVERRUN_EN
    total++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun: got %0b expected 0", overrun); else passed++;
`endif
  endtask

  task automatic test_ramp();
    logic exp_v;
    logic signed [W-1:0] exp_c;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      cyc(n, 1'b1, 1'b1);
      exp_v = ((n % 4) == 3);
      total++;
      if (valid !== exp_v) $display("FAIL ramp_valid n=%0d: got %0b expected %0b", n, valid, exp_v);
      else passed++;
      if (exp_v) begin
        exp_c = (n == 3) ? W'(3) : W'(4);
        total++;
        if (comb !== exp_c) $display("FAIL ramp_comb n=%0d: got %0d expected %0d", n, comb, exp_c);
        else passed++;
      end
    end
  endtask

  task automatic test_constant();
    logic signed [W-1:0] exp_c;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      cyc(100, 1'b1, 1'b1);
      if ((n % 4) == 3) begin
        exp_c = (n == 3) ? W'(100) : W'(0);
        total++;
        if (valid !== 1'b1 || comb !== exp_c)
          $display("FAIL const n=%0d: got valid=%0b comb=%0d expected valid=1 comb=%0d", n, valid, comb, exp_c);
        else passed++;
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 0; n < 8; n++) begin
      cyc((n < 4) ? 500 : -508, 1'b1, 1'b1);
      if (n == 3) begin
        total++;
        if (valid !== 1'b1 || comb !== W'(500))
          $display("FAIL wrap_first: got valid=%0b comb=%0d expected valid=1 comb=500", valid, comb);
        else passed++;
      end
      if (n == 7) begin
        total++;
        if (valid !== 1'b1 || comb !== W'(16))
          $display("FAIL wrap_diff: got valid=%0b comb=%0d expected valid=1 comb=16", valid, comb);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic exp_v;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      cyc(n, 1'b1, (n >= 8));
      exp_v = (n >= 3 && n <= 7) || (n == 11);
      total++;
      if (valid !== exp_v) $display("FAIL bp_valid n=%0d: got %0b expected %0b", n, valid, exp_v);
      else passed++;
      if (n >= 3 && n <= 7) begin
        total++;
        if (comb !== W'(3)) $display("FAIL bp_hold n=%0d: got %0d expected 3", n, comb);
        else passed++;
      end
      if (n == 11) begin
        total++;
        if (comb !== W'(4)) $display("FAIL bp_next: got %0d expected 4", comb);
        else passed++;
      end
`ifdef COMB_OVERRUN_EN
      total++;
      if (overrun !== (n >= 7)) $display("FAIL bp_overrun n=%0d: got %0b expected %0b", n, overrun, (n >= 7));
      else passed++;
`endif
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int n = 0; n < 9; n++) begin
      cyc(n, 1'b1, (n >= 7));
      if (n >= 3 && n <= 6) begin
        total++;
        if (valid !== 1'b1 || comb !== W'(3))
          $display("FAIL sim_hold n=%0d: got valid=%0b comb=%0d expected valid=1 comb=3", n, valid, comb);
        else passed++;
      end
      if (n == 7) begin
        total++;
        if (valid !== 1'b1 || comb !== W'(4))
          $display("FAIL sim_reload: got valid=%0b comb=%0d expected valid=1 comb=4", valid, comb);
        else passed++;
      end
      if (n == 8) begin
        total++;
        if (valid !== 1'b0) $display("FAIL sim_drain: got %0b expected 0", valid);
        else passed++;
      end
`ifdef COMB_OVERRUN_EN
      total++;
      if (overrun !== 1'b0) $display("FAIL sim_overrun n=%0d: got %0b expected 0", n, overrun);
      else passed++;
`endif
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int n = 0; n < 6; n++) cyc(n, 1'b1, 1'b0);
    total++;
    if (valid !== 1'b1 || comb !== W'(3))
      $display("FAIL rmid_pre: got valid=%0b comb=%0d expected valid=1 comb=3", valid, comb);
    else passed++;
    #3;
    rstn = 1'b0;
    #1;
    total++;
    if (valid !== 1'b0 || comb !== '0)
      $display("FAIL rmid_async: got valid=%0b comb=%0d expected valid=0 comb=0", valid, comb);
    else passed++;
    @(posedge clk);
    #3;
    rstn = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cyc(20 + n, 1'b1, 1'b1);
      total++;
      if (valid !== (n == 3)) $display("FAIL rmid_valid n=%0d: got %0b expected %0b", n, valid, (n == 3));
      else passed++;
    end
    total++;
    if (comb !== W'(23)) $display("FAIL rmid_first: got %0d expected 23", comb);
    else passed++;
  endtask

  task automatic test_enable();
    logic e;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      e = !(c >= 2 && c <= 6);
      cyc(c, e, 1'b1);
      total++;
      if (valid !== (c == 8)) $display("FAIL en_valid c=%0d: got %0b expected %0b", c, valid, (c == 8));
      else passed++;
      if (c == 8) begin
        total++;
        if (comb !== W'(8)) $display("FAIL en_comb: got %0d expected 8", comb);
        else passed++;
      end
    end
  endtask

  initial begin
    rstn  = 1'b0;
    en    = 1'b1;
    ready = 1'b1;
    integ = '0;
    test_reset();
    test_ramp();
    test_constant();
    test_wrap();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_enable();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
